// File: rtl/mips_pkg.sv
// Shared types and constants for the branch-offset encode path.
// Word-offset immediates are IMM_W bits, counted from PC + PC_INC.
// Pure declarations; no logic, no latency, no backpressure.
package mips_pkg;
    localparam int IMM_W      = 16;
    localparam int WORD_SHIFT = 2;
    localparam int PC_INC     = 4;
    localparam int DIFF_W     = 33;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        sign;
    } boe_req_t;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        logic             misalign;
        logic             ovf;
    } boe_rsp_t;
endpackage

// File: rtl/boe_range_chk.sv
// Classifies a 33-bit byte offset: misalignment and 16-bit word-offset range (BOE_RANGE_CHECK_EN).
// Combinational, zero latency.
// No handshake; the caller registers the result.
module boe_range_chk
    import mips_pkg::*;
(
    input  logic [DIFF_W-1:0] diff,
    input  logic              sign,
    output logic              misalign,
    output logic              ovf
);
    logic unused_bits;

    assign misalign = (diff[WORD_SHIFT-1:0] != '0);

`ifdef BOE_RANGE_CHECK_EN
    // Signed: the bits above the immediate must replicate its sign bit.
    // Unsigned: the extender zero-fills, so everything above must be zero.
    assign ovf = sign ? !((diff[32:17] == '0) || (diff[32:17] == '1))
                      : (diff[32:18] != '0);
    assign unused_bits = ^diff[16:2];
`else
    assign ovf = 1'b0;
    assign unused_bits = ^{sign, diff[32:2]};
`endif
endmodule

// File: rtl/branch_offset_encoder.sv
// Encodes branch PC/target into a 16-bit word-offset immediate; range check guarded by BOE_RANGE_CHECK_EN.
// Latency 2 cycles (S1 difference, S2 classified result), one result per cycle.
// Backpressure: out_ready low freezes S2; in_ready drops only when S1 is also occupied.
module branch_offset_encoder
    import mips_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_target,
    input  logic                 in_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IMM_W-1:0]     out_imm,
    output logic                 out_misalign,
    output logic                 out_ovf,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    boe_req_t          req;
    logic [DIFF_W-1:0] diff_next;
    logic              s1_valid;
    logic [DIFF_W-1:0] s1_diff;
    logic              s1_sign;
    boe_rsp_t          s1_rsp;
    boe_rsp_t          s2_rsp;
    logic              s2_load;
    logic              in_fire;
    logic              out_fire;

    assign req       = '{pc: in_pc, target: in_target, sign: in_sign};
    // Sign-extend both to 33 bits so wrap across address zero stays exact.
    assign diff_next = {req.target[31], req.target} - {req.pc[31], req.pc} - DIFF_W'(PC_INC);

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    boe_range_chk u_range_chk (
        .diff     (s1_diff),
        .sign     (s1_sign),
        .misalign (s1_rsp.misalign),
        .ovf      (s1_rsp.ovf)
    );
    assign s1_rsp.imm = s1_diff[WORD_SHIFT +: IMM_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_diff   <= '0;
            s1_sign   <= 1'b0;
            out_valid <= 1'b0;
            s2_rsp    <= '0;
            err_cnt   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_diff  <= diff_next;
                s1_sign  <= req.sign;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end

            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    s2_rsp <= s1_rsp;
                end
            end

            if (out_fire && (s2_rsp.misalign || s2_rsp.ovf) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign out_imm      = s2_rsp.imm;
    assign out_misalign = s2_rsp.misalign;
    assign out_ovf      = s2_rsp.ovf;
endmodule
